wb_mem_arbiter: RTL and testbench
=================================

// Module: wb_mem_arbiter
// PURPOSE
//  Two-master arbiter in front of the data memory (mem_byte slave). Masters: core M-stage port (always-on,
//  single-cycle) and the UART Wishbone bridge (classic cyc/stb/ack). Replaces the static i_select_mem mux.
//  Freezes the core via o_core_stall while the UART owns the bus, so core and UART accesses never collide.
//  Bounds every UART transaction with an ack-timeout counter.
// PARAMETERS
//  DATA_WIDTH      32   data bus width
//  MEM_ADDR_WIDTH  9    slave word/byte address width (low bits of master addresses)
//  TIMEOUT_CYCLES  16   max cycles UART waits for slave ack before error-terminate (>=2)
// PORTS
//  clk             in   1    system clock, single clock domain
//  rst             in   1    synchronous, active-high reset
//  i_core_we       in   1    core store enable (M stage)
//  i_core_adr      in   32   core data address
//  i_core_dat      in   32   core write data
//  i_core_funct3   in   3    core load/store size
//  o_core_dat      out  32   read data to core
//  o_core_stall    out  1    freeze core pipeline (PC + stage regs)
//  i_uart_cyc      in   1    UART bridge cycle
//  i_uart_stb      in   1    UART bridge strobe
//  i_uart_we       in   1    UART write enable
//  i_uart_adr      in   32   UART address
//  i_uart_dat      in   32   UART write data
//  o_uart_dat      out  32   read data to UART bridge
//  o_uart_ack      out  1    one-cycle ack to UART bridge
//  o_uart_err      out  1    one-cycle error (timeout), asserted instead of ack
//  o_mem_cyc/stb/we out 1   slave controls
//  o_mem_adr       out  MEM_ADDR_WIDTH  slave address
//  o_mem_dat       out  32   slave write data
//  o_mem_funct3    out  3    slave access size (3'b010 forced for UART)
//  i_mem_dat       in   32   slave read data
//  i_mem_ack       in   1    slave ack
// BEHAVIOUR
//  Reset: state=S_CORE; o_core_stall=0, o_uart_ack=0, o_uart_err=0, timeout cnt=0.
//  S_CORE: core drives mem combinationally (cyc=stb=1, we=i_core_we, funct3=i_core_funct3).
//   i_uart_cyc&i_uart_stb sampled high -> S_STALL; o_core_stall=1 registered from next cycle.
//  S_STALL (1 cycle): stall=1, mem cyc/stb=0, we=0 -> lets in-flight core access retire. -> S_UART.
//  S_UART: mem driven by UART (adr low bits, we, dat, funct3=3'b010); cnt increments each cycle.
//   i_mem_ack -> o_uart_ack=1 for exactly one cycle, o_uart_dat=i_mem_dat captured; -> S_RELEASE.
//   cnt==TIMEOUT_CYCLES-1 without ack -> o_uart_err=1 one cycle, no ack; -> S_RELEASE.
//   Ack and timeout same cycle: ack wins, no err.
//  S_RELEASE: mem stb=0; stall held; wait until i_uart_stb==0 -> S_CORE, stall deasserts same edge.
//   New UART stb while already in S_RELEASE with stb never dropped: not re-served (edge per transaction).
//  UART drops cyc mid S_STALL/S_UART (abort): -> S_RELEASE, no ack/err, mem we forced 0 that cycle.
//  o_core_stall and all o_uart_* registered; o_mem_* combinational from state + selected master.
//  o_core_dat = i_mem_dat always (core ignores it while stalled). cnt cleared on entry to S_UART.
//  rst mid-transaction: immediate return to S_CORE, pending UART transfer dropped, no ack.
// STRUCTURE
//  Shared package/include: state encodings (S_CORE,S_STALL,S_UART,S_RELEASE, 2 bits) and
//   FUNCT3_WORD=3'b010, reused by core LSU and bridge.
//  One sub-module natural: wb_timeout_counter (enable/clear/expire, width $clog2(TIMEOUT_CYCLES)).
// TESTING
//  Core store adr=0x10 dat=0xDEADBEEF, no UART -> mem we=1 same cycle, stall stays 0.
//  UART write adr=0x20 dat=0x12345678, slave ack after 3 cycles -> stall high 1 cycle after stb,
//   o_uart_ack one pulse, stall drops when stb falls; later core load 0x20 returns 0x12345678.
//  UART read with slave never acking, TIMEOUT_CYCLES=16 -> o_uart_err pulse 16 cycles into S_UART,
//   no ack, core resumes after stb drop.
//  Core store asserted same cycle UART stb rises -> core store completes, UART granted after S_STALL,
//   no mem write in S_STALL cycle.
//  Ack on exactly timeout cycle -> ack=1, err=0.
//  rst asserted during S_UART -> next cycle state S_CORE, stall=0, ack=0, err=0.

Source files
------------

// File: rtl/wb_mem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter and its neighbours.
// - arb_state_t : arbiter FSM encoding (2 bits), also exported on the debug port
// - FUNCT3_WORD : load/store size code for a full 32-bit word access
// - uart_request: classic Wishbone request qualifier (cyc & stb)
package wb_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_CORE    = 2'd0,
    S_STALL   = 2'd1,
    S_UART    = 2'd2,
    S_RELEASE = 2'd3
  } arb_state_t;

  localparam logic [2:0] FUNCT3_WORD = 3'b010;

  function automatic logic uart_request(input logic cyc, input logic stb);
    return cyc & stb;
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Ack-timeout counter for one bus transaction.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   en        : count while the transaction is outstanding
//   clr       : return to zero (held while no transaction is outstanding)
//   expire    : high during the TIMEOUT_CYCLES-th enabled cycle (cnt == TIMEOUT_CYCLES-1)
module wb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt;

  assign expire = en && (cnt == CW'(TIMEOUT_CYCLES - 1));

  // Saturates at the terminal value so a held enable can never wrap back
  // to zero and retrigger.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Two-master arbiter in front of the data memory slave.
// Master 0: core M-stage port, single-cycle, owns the bus by default.
// Master 1: UART Wishbone bridge (classic cyc/stb/ack), served on request;
//           the core is frozen through o_core_stall while the UART owns the bus.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   i_core_we/adr/dat/funct3      : core access request (always active)
//   o_core_dat                    : read data to core (straight from the slave)
//   o_core_stall                  : registered pipeline freeze
//   i_uart_cyc/stb/we/adr/dat     : UART bridge request
//   o_uart_dat/ack/err            : registered response (ack or err, one-cycle pulse)
//   o_mem_cyc/stb/we/adr/dat/funct3 : slave request (combinational)
//   i_mem_dat, i_mem_ack          : slave response
//   o_dbg_state                   : current arbiter state
//
// Handshake: a UART transaction is requested while cyc&stb are high in S_CORE.
// It is answered by exactly one of ack/err for one cycle, and the bus is handed
// back to the core only once the bridge has dropped stb, so each stb assertion
// is served once. Dropping cyc before the answer aborts with no ack/err.
module wb_mem_arbiter
  import wb_mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 9,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_core_we,
  input  logic [31:0]               i_core_adr,
  input  logic [DATA_WIDTH-1:0]     i_core_dat,
  input  logic [2:0]                i_core_funct3,
  output logic [DATA_WIDTH-1:0]     o_core_dat,
  output logic                      o_core_stall,
  input  logic                      i_uart_cyc,
  input  logic                      i_uart_stb,
  input  logic                      i_uart_we,
  input  logic [31:0]               i_uart_adr,
  input  logic [DATA_WIDTH-1:0]     i_uart_dat,
  output logic [DATA_WIDTH-1:0]     o_uart_dat,
  output logic                      o_uart_ack,
  output logic                      o_uart_err,
  output logic                      o_mem_cyc,
  output logic                      o_mem_stb,
  output logic                      o_mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] o_mem_adr,
  output logic [DATA_WIDTH-1:0]     o_mem_dat,
  output logic [2:0]                o_mem_funct3,
  input  logic [DATA_WIDTH-1:0]     i_mem_dat,
  input  logic                      i_mem_ack,
  output arb_state_t                o_dbg_state
);

  arb_state_t state, state_n;
  logic       tmo_expire;

  // Only the low address bits reach the slave.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{i_core_adr[31:MEM_ADDR_WIDTH], i_uart_adr[31:MEM_ADDR_WIDTH]};

  assign o_dbg_state = state;
  assign o_core_dat  = i_mem_dat;

  // Counter is held at zero outside S_UART, so it always starts a
  // transaction from zero.
  wb_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .en     (state == S_UART),
    .clr    (state != S_UART),
    .expire (tmo_expire)
  );

  always_comb begin
    state_n = state;
    case (state)
      S_CORE:    if (uart_request(i_uart_cyc, i_uart_stb)) state_n = S_STALL;
      // One dead cycle lets the core access issued on the grant edge retire.
      S_STALL:   state_n = i_uart_cyc ? S_UART : S_RELEASE;
      S_UART:    if (!i_uart_cyc || i_mem_ack || tmo_expire) state_n = S_RELEASE;
      S_RELEASE: if (!i_uart_stb) state_n = S_CORE;
      default:   state_n = S_CORE;
    endcase
  end

  always_comb begin
    o_mem_cyc    = 1'b0;
    o_mem_stb    = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_adr    = i_core_adr[MEM_ADDR_WIDTH-1:0];
    o_mem_dat    = i_core_dat;
    o_mem_funct3 = i_core_funct3;
    case (state)
      S_CORE: begin
        o_mem_cyc = 1'b1;
        o_mem_stb = 1'b1;
        o_mem_we  = i_core_we;
      end
      S_UART: begin
        // An abort (cyc dropped) must not leave a write strobe on the slave.
        o_mem_cyc    = i_uart_cyc;
        o_mem_stb    = i_uart_cyc;
        o_mem_we     = i_uart_we & i_uart_cyc;
        o_mem_adr    = i_uart_adr[MEM_ADDR_WIDTH-1:0];
        o_mem_dat    = i_uart_dat;
        o_mem_funct3 = FUNCT3_WORD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_CORE;
      o_core_stall <= 1'b0;
      o_uart_ack   <= 1'b0;
      o_uart_err   <= 1'b0;
      o_uart_dat   <= '0;
    end else begin
      state        <= state_n;
      o_core_stall <= (state_n != S_CORE);
      o_uart_ack   <= 1'b0;
      o_uart_err   <= 1'b0;
      if (state == S_UART && i_uart_cyc) begin
        // Ack has priority over a timeout landing in the same cycle.
        if (i_mem_ack) begin
          o_uart_ack <= 1'b1;
          o_uart_dat <= i_mem_dat;
        end else if (tmo_expire) begin
          o_uart_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
module tb_wb_mem_arbiter;
  import wb_mem_arbiter_pkg::*;

  localparam int T  = 16;
  localparam int AW = 9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          i_core_we, i_uart_cyc, i_uart_stb, i_uart_we, i_mem_ack;
  logic [31:0]   i_core_adr, i_core_dat, i_uart_adr, i_uart_dat, i_mem_dat;
  logic [2:0]    i_core_funct3;
  logic [31:0]   o_core_dat, o_uart_dat, o_mem_dat;
  logic          o_core_stall, o_uart_ack, o_uart_err, o_mem_cyc, o_mem_stb, o_mem_we;
  logic [AW-1:0] o_mem_adr;
  logic [2:0]    o_mem_funct3;
  arb_state_t    o_dbg_state;

  wb_mem_arbiter #(.DATA_WIDTH(32), .MEM_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .i_core_we(i_core_we), .i_core_adr(i_core_adr), .i_core_dat(i_core_dat),
    .i_core_funct3(i_core_funct3), .o_core_dat(o_core_dat), .o_core_stall(o_core_stall),
    .i_uart_cyc(i_uart_cyc), .i_uart_stb(i_uart_stb), .i_uart_we(i_uart_we),
    .i_uart_adr(i_uart_adr), .i_uart_dat(i_uart_dat), .o_uart_dat(o_uart_dat),
    .o_uart_ack(o_uart_ack), .o_uart_err(o_uart_err),
    .o_mem_cyc(o_mem_cyc), .o_mem_stb(o_mem_stb), .o_mem_we(o_mem_we),
    .o_mem_adr(o_mem_adr), .o_mem_dat(o_mem_dat), .o_mem_funct3(o_mem_funct3),
    .i_mem_dat(i_mem_dat), .i_mem_ack(i_mem_ack), .o_dbg_state(o_dbg_state)
  );

  // ---------------- slave model: sync-write RAM, ack after slv_delay strobed cycles ----------------
  logic [31:0] slv_mem [0:(1<<AW)-1];
  logic        slv_clear = 1'b1;
  int          slv_cnt   = 0;
  int          slv_delay = 1000;

  always @(posedge clk) begin
    if (slv_clear) begin
      for (int i = 0; i < (1 << AW); i++) slv_mem[i] <= '0;
    end else if (o_mem_cyc && o_mem_stb && o_mem_we) begin
      slv_mem[o_mem_adr] <= o_mem_dat;
    end
    slv_cnt <= (o_mem_cyc && o_mem_stb) ? slv_cnt + 1 : 0;
  end

  assign i_mem_dat = slv_mem[o_mem_adr];
  assign i_mem_ack = o_mem_cyc && o_mem_stb && (slv_cnt == slv_delay);

  // ---------------- reference model: contents the system should hold ----------------
  logic [31:0] ref_mem [0:(1<<AW)-1];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks (entered and left at a negedge) ----------------
  task automatic core_store(input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] f3);
    i_core_we = 1'b1; i_core_adr = adr; i_core_dat = dat; i_core_funct3 = f3;
    #1;
    check("core_st_we", o_mem_we, 1);
    check("core_st_adr", o_mem_adr, adr[AW-1:0]);
    check("core_st_dat", o_mem_dat, dat);
    check("core_st_f3", o_mem_funct3, f3);
    check("core_st_stall", o_core_stall, 0);
    @(negedge clk);
    i_core_we = 1'b0;
    ref_mem[adr[AW-1:0]] = dat;
  endtask

  task automatic core_load(input logic [31:0] adr);
    i_core_we = 1'b0; i_core_adr = adr; i_core_funct3 = FUNCT3_WORD;
    #1;
    check("core_ld_dat", o_core_dat, ref_mem[adr[AW-1:0]]);
    check("core_ld_stall", o_core_stall, 0);
    @(negedge clk);
  endtask

  // Full UART transaction; optionally a core store is presented on the same
  // cycle the UART request rises. delay = slave ack latency in S_UART cycles.
  task automatic uart_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input int delay, input logic with_core,
                          input logic [31:0] c_adr, input logic [31:0] c_dat);
    int   n, exp_n;
    logic done, exp_ack;
    exp_ack   = (delay <= T - 1);
    exp_n     = exp_ack ? delay + 3 : T + 2;
    slv_delay = delay;
    i_uart_cyc = 1'b1; i_uart_stb = 1'b1; i_uart_we = we; i_uart_adr = adr; i_uart_dat = dat;
    if (with_core) begin
      i_core_we = 1'b1; i_core_adr = c_adr; i_core_dat = c_dat; i_core_funct3 = FUNCT3_WORD;
      #1;
      check("ovl_core_we", o_mem_we, 1);
      check("ovl_core_adr", o_mem_adr, c_adr[AW-1:0]);
    end
    @(negedge clk);
    n = 1;
    check("stall_rise", o_core_stall, 1);
    check("stall_state", o_dbg_state, S_STALL);
    check("stall_mem_off", {o_mem_cyc, o_mem_stb, o_mem_we}, 3'b000);
    if (with_core) begin
      i_core_we = 1'b0;
      ref_mem[c_adr[AW-1:0]] = c_dat;
    end
    done = 1'b0;
    while (!done && n < T + 8) begin
      @(negedge clk);
      n++;
      if (n == 2) begin
        check("uart_mem_cyc", o_mem_cyc, 1);
        check("uart_mem_we", o_mem_we, we);
        check("uart_mem_adr", o_mem_adr, adr[AW-1:0]);
        check("uart_mem_dat", o_mem_dat, dat);
        check("uart_mem_f3", o_mem_funct3, FUNCT3_WORD);
      end
      if (o_uart_ack || o_uart_err) done = 1'b1;
    end
    check("uart_done", done, 1);
    check("uart_resp_cycle", n, exp_n);
    check("uart_ack", o_uart_ack, exp_ack);
    check("uart_err", o_uart_err, !exp_ack);
    if (exp_ack && !we) check("uart_rdata", o_uart_dat, ref_mem[adr[AW-1:0]]);
    if (exp_ack && we) ref_mem[adr[AW-1:0]] = dat;
    // stb still high: response must not repeat and the core stays frozen
    @(negedge clk);
    check("resp_pulse_ack", o_uart_ack, 0);
    check("resp_pulse_err", o_uart_err, 0);
    check("release_stall", o_core_stall, 1);
    check("release_mem_stb", o_mem_stb, 0);
    i_uart_cyc = 1'b0; i_uart_stb = 1'b0; i_uart_we = 1'b0;
    @(negedge clk);
    check("resume_stall", o_core_stall, 0);
    check("resume_state", o_dbg_state, S_CORE);
    slv_delay = 1000;
  endtask

  // ---------------- directed + randomized sequence ----------------
  initial begin
    logic [31:0] a, d, hi;
    int op;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
    i_core_we = 0; i_core_adr = 0; i_core_dat = 0; i_core_funct3 = FUNCT3_WORD;
    i_uart_cyc = 0; i_uart_stb = 0; i_uart_we = 0; i_uart_adr = 0; i_uart_dat = 0;
    repeat (3) @(negedge clk);
    check("rst_state", o_dbg_state, S_CORE);
    check("rst_stall", o_core_stall, 0);
    check("rst_ack", o_uart_ack, 0);
    check("rst_err", o_uart_err, 0);
    check("rst_udat", o_uart_dat, 0);
    rst = 1'b0; slv_clear = 1'b0;
    @(negedge clk);
    check("idle_core_owns", o_mem_cyc, 1);

    core_store(32'h10, 32'hDEAD_BEEF, FUNCT3_WORD);
    core_load(32'h10);
    uart_txn(1'b1, 32'h20, 32'h1234_5678, 3, 1'b0, 0, 0);
    core_load(32'h20);
    uart_txn(1'b0, 32'h20, 32'h0, 1000, 1'b0, 0, 0);        // timeout
    uart_txn(1'b0, 32'h20, 32'h0, T - 1, 1'b0, 0, 0);       // ack on the timeout cycle
    uart_txn(1'b1, 32'h31, 32'hA5A5_5A5A, 2, 1'b1, 32'h30, 32'hCAFE_F00D);
    core_load(32'h30);
    core_load(32'h31);

    // abort: cyc dropped during S_STALL
    slv_delay = 0;
    i_uart_cyc = 1; i_uart_stb = 1; i_uart_we = 1; i_uart_adr = 32'h40; i_uart_dat = 32'h7777_7777;
    @(negedge clk);
    check("abort_stall_state", o_dbg_state, S_STALL);
    i_uart_cyc = 0; i_uart_stb = 0;
    @(negedge clk);
    check("abort_release", o_dbg_state, S_RELEASE);
    check("abort_ack", o_uart_ack, 0);
    check("abort_err", o_uart_err, 0);
    check("abort_stall", o_core_stall, 1);
    @(negedge clk);
    check("abort_resume", o_core_stall, 0);
    i_uart_we = 0; slv_delay = 1000;
    core_load(32'h40);

    // reset while the UART owns the bus
    i_uart_cyc = 1; i_uart_stb = 1; i_uart_we = 0; i_uart_adr = 32'h20;
    repeat (3) @(negedge clk);
    check("pre_rst_uart", o_dbg_state, S_UART);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_state", o_dbg_state, S_CORE);
    check("mid_rst_stall", o_core_stall, 0);
    check("mid_rst_ack", o_uart_ack, 0);
    check("mid_rst_err", o_uart_err, 0);
    rst = 1'b0; i_uart_cyc = 0; i_uart_stb = 0;
    @(negedge clk);
    check("post_rst_state", o_dbg_state, S_CORE);
    core_load(32'h10);

    // randomized mix; upper address bits must be ignored
    for (int k = 0; k < 14; k++) begin
      op = $urandom_range(0, 3);
      hi = $urandom & 32'hFFFF_FE00;
      a  = hi | 32'($urandom_range(0, 63));
      d  = $urandom;
      case (op)
        0: core_store(a, d, 3'($urandom_range(0, 2)));
        1: core_load(a);
        2: uart_txn(1'b1, a, d, $urandom_range(0, T - 1), 1'b0, 0, 0);
        default: uart_txn(1'b0, a, d, $urandom_range(0, T + 3), 1'b0, 0, 0);
      endcase
      if (op >= 2) core_load(a);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
